// File: rtl/board_turn_arbiter.sv
// Two-player turn scheduler for a 4x4 board. It arbitrates move requests and sequences each
// accepted move through position update, visited map, prize and score.
module board_turn_arbiter #(
  parameter int unsigned SCORE_W   = 6,
  parameter int unsigned MAX_TURNS = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_a,
  input  logic [1:0]         dir_a,
  input  logic               req_b,
  input  logic [1:0]         dir_b,
  output logic               grant_a,
  output logic               grant_b,
  output logic [3:0]         pos_a,
  output logic [3:0]         pos_b,
  output logic [3:0]         prize,
  output logic               prize_valid,
  output logic               blocked,
  output logic [SCORE_W-1:0] score_a,
  output logic [SCORE_W-1:0] score_b,
  output logic [15:0]        visited,
  output logic               turn,
  output logic               game_over
);

  localparam int unsigned        SumW      = SCORE_W + 1;
  localparam logic [SCORE_W-1:0] ScoreMax  = '1;
  localparam logic [7:0]         TurnLimit = 8'(MAX_TURNS);

  typedef enum logic [1:0] {StIdle, StMove, StScore, StDone} state_e;

  state_e             state_q, state_d;
  logic               mover_q, mover_d;  // 0 = A, 1 = B
  logic [1:0]         dir_q, dir_d;
  logic [3:0]         pos_a_q, pos_a_d;
  logic [3:0]         pos_b_q, pos_b_d;
  logic [15:0]        visited_q, visited_d;
  logic [SCORE_W-1:0] score_a_q, score_a_d;
  logic [SCORE_W-1:0] score_b_q, score_b_d;
  logic [3:0]         prize_q, prize_d;
  logic               prize_valid_q, prize_valid_d;
  logic               blocked_q, blocked_d;
  logic               turn_q, turn_d;
  logic [7:0]         count_q, count_d;
  logic               grant_a_q, grant_a_d;
  logic               grant_b_q, grant_b_d;
  logic               game_over_q, game_over_d;

  logic [3:0]         mover_pos, opp_pos, target;
  logic [1:0]         coord_step;
  logic               move_blocked;
  logic [2:0]         prize_calc;
  logic [SCORE_W-1:0] mover_score, score_next;
  logic [SumW-1:0]    score_sum;
  logic               pick_a;

  // Move evaluation, used only while in StMove.
  always_comb begin
    mover_pos  = mover_q ? pos_b_q : pos_a_q;
    opp_pos    = mover_q ? pos_a_q : pos_b_q;
    coord_step = dir_q[0] ? 2'd1 : 2'd3;
    target     = mover_pos;
    if (dir_q[1]) begin
      target[1:0] = mover_pos[1:0] + coord_step;
    end else begin
      target[3:2] = mover_pos[3:2] + coord_step;
    end
    move_blocked = (target == opp_pos);
    if (move_blocked || visited_q[target]) begin
      prize_calc = 3'd0;
    end else begin
      prize_calc = {1'b0, target[1:0]} + {1'b0, target[3:2]};
    end
    mover_score = mover_q ? score_b_q : score_a_q;
    score_sum   = {1'b0, mover_score} + SumW'(prize_calc);
    score_next  = score_sum[SumW-1] ? ScoreMax : score_sum[SCORE_W-1:0];
  end

  // The turn holder wins a tie; a lone requester always wins.
  assign pick_a = req_a && (!req_b || !turn_q);

  always_comb begin
    state_d       = state_q;
    mover_d       = mover_q;
    dir_d         = dir_q;
    pos_a_d       = pos_a_q;
    pos_b_d       = pos_b_q;
    visited_d     = visited_q;
    score_a_d     = score_a_q;
    score_b_d     = score_b_q;
    prize_d       = prize_q;
    turn_d        = turn_q;
    count_d       = count_q;
    game_over_d   = game_over_q;
    prize_valid_d = 1'b0;
    blocked_d     = 1'b0;
    grant_a_d     = 1'b0;
    grant_b_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pick_a) begin
          mover_d   = 1'b0;
          dir_d     = dir_a;
          grant_a_d = 1'b1;
          state_d   = StMove;
        end else if (req_b) begin
          mover_d   = 1'b1;
          dir_d     = dir_b;
          grant_b_d = 1'b1;
          state_d   = StMove;
        end
      end
      StMove: begin
        if (!move_blocked) begin
          if (mover_q) begin
            pos_b_d = target;
          end else begin
            pos_a_d = target;
          end
          visited_d[target] = 1'b1;
        end
        if (mover_q) begin
          score_b_d = score_next;
        end else begin
          score_a_d = score_next;
        end
        prize_d       = {1'b0, prize_calc};
        blocked_d     = move_blocked;
        prize_valid_d = 1'b1;
        turn_d        = ~mover_q;
        count_d       = count_q + 8'd1;
        state_d       = StScore;
      end
      StScore: begin
        if ((&visited_q) || (count_q == TurnLimit)) begin
          state_d     = StDone;
          game_over_d = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      StDone: begin
        state_d = StDone;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      mover_q       <= 1'b0;
      dir_q         <= 2'b00;
      pos_a_q       <= 4'd0;
      pos_b_q       <= 4'd15;
      visited_q     <= 16'h8001;
      score_a_q     <= '0;
      score_b_q     <= '0;
      prize_q       <= 4'd0;
      prize_valid_q <= 1'b0;
      blocked_q     <= 1'b0;
      turn_q        <= 1'b0;
      count_q       <= 8'd0;
      grant_a_q     <= 1'b0;
      grant_b_q     <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      mover_q       <= mover_d;
      dir_q         <= dir_d;
      pos_a_q       <= pos_a_d;
      pos_b_q       <= pos_b_d;
      visited_q     <= visited_d;
      score_a_q     <= score_a_d;
      score_b_q     <= score_b_d;
      prize_q       <= prize_d;
      prize_valid_q <= prize_valid_d;
      blocked_q     <= blocked_d;
      turn_q        <= turn_d;
      count_q       <= count_d;
      grant_a_q     <= grant_a_d;
      grant_b_q     <= grant_b_d;
      game_over_q   <= game_over_d;
    end
  end

  assign grant_a     = grant_a_q;
  assign grant_b     = grant_b_q;
  assign pos_a       = pos_a_q;
  assign pos_b       = pos_b_q;
  assign prize       = prize_q;
  assign prize_valid = prize_valid_q;
  assign blocked     = blocked_q;
  assign score_a     = score_a_q;
  assign score_b     = score_b_q;
  assign visited     = visited_q;
  assign turn        = turn_q;
  assign game_over   = game_over_q;

endmodule

// File: tb/tb_board_turn_arbiter.sv
// Scoreboard bench for board_turn_arbiter: a game-level model predicts grants and move results,
// and a monitor checks them whenever the DUT pulses grant or prize_valid.
module tb_board_turn_arbiter;

  localparam int unsigned SW   = 3;
  localparam int unsigned MAXT = 20;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_a = 1'b0, req_b = 1'b0;
  logic [1:0]    dir_a = 2'b00, dir_b = 2'b00;
  logic          grant_a, grant_b, prize_valid, blocked, turn, game_over;
  logic [3:0]    pos_a, pos_b, prize;
  logic [SW-1:0] score_a, score_b;
  logic [15:0]   visited;

  board_turn_arbiter #(.SCORE_W(SW), .MAX_TURNS(MAXT)) u_dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .dir_a(dir_a), .req_b(req_b), .dir_b(dir_b),
    .grant_a(grant_a), .grant_b(grant_b),
    .pos_a(pos_a), .pos_b(pos_b), .prize(prize), .prize_valid(prize_valid),
    .blocked(blocked), .score_a(score_a), .score_b(score_b), .visited(visited),
    .turn(turn), .game_over(game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pa, pb, pz, blk, sa, sb, vis, trn, done;
  } res_t;

  int   n_vec = 0;
  int   n_err = 0;
  int   exp_grant[$];
  res_t exp_res[$];
  res_t last;
  bit   go_exp = 0;
  bit   mon_en = 0;

  // Game-level reference state.
  int mx[2], my[2], sc[2], cnt, wait_cnt;
  bit vis[16];
  bit m_turn, m_done;
  bit drop[2];

  function automatic void chk(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic res_t snapshot(int pz, int blk);
    res_t r;
    r.pa  = my[0] * 4 + mx[0];
    r.pb  = my[1] * 4 + mx[1];
    r.pz  = pz;
    r.blk = blk;
    r.sa  = sc[0];
    r.sb  = sc[1];
    r.vis = 0;
    for (int i = 0; i < 16; i++) if (vis[i]) r.vis += (1 << i);
    r.trn  = m_turn;
    r.done = m_done;
    return r;
  endfunction

  function automatic void model_init();
    mx[0] = 0; my[0] = 0; mx[1] = 3; my[1] = 3;
    sc[0] = 0; sc[1] = 0; cnt = 0; wait_cnt = 0;
    for (int i = 0; i < 16; i++) vis[i] = (i == 0 || i == 15);
    m_turn = 0; m_done = 0; drop[0] = 0; drop[1] = 0;
    exp_grant.delete();
    exp_res.delete();
    last   = snapshot(0, 0);
    go_exp = 0;
  endfunction

  function automatic void model_move(int p, logic [1:0] d);
    int tx, ty, tc, pz, nvis, smax;
    bit blk;
    tx = mx[p];
    ty = my[p];
    if (d[1]) tx = (tx + (d[0] ? 1 : 3)) % 4;
    else      ty = (ty + (d[0] ? 1 : 3)) % 4;
    blk = (tx == mx[1-p]) && (ty == my[1-p]);
    tc  = ty * 4 + tx;
    pz  = (blk || vis[tc]) ? 0 : tx + ty;
    if (!blk) begin
      mx[p] = tx; my[p] = ty; vis[tc] = 1;
    end
    smax  = (1 << SW) - 1;
    sc[p] = (sc[p] + pz > smax) ? smax : sc[p] + pz;
    m_turn = (p == 0);
    cnt++;
    nvis = 0;
    for (int i = 0; i < 16; i++) nvis += vis[i];
    m_done = (nvis == 16) || (cnt == MAXT);
    exp_res.push_back(snapshot(pz, blk));
  endfunction

  // One clock of stimulus; the model decides what the DUT accepts at the coming edge.
  task automatic step(input bit rnd, input bit fa, input logic [1:0] da,
                      input bit fb, input logic [1:0] db);
    int p;
    @(negedge clk);
    if (drop[0]) begin req_a = 0; drop[0] = 0; end
    else if (fa) begin req_a = 1; dir_a = da; end
    else if (rnd && !req_a && $urandom_range(0, 2) == 0) begin
      req_a = 1; dir_a = 2'($urandom_range(0, 3));
    end
    if (drop[1]) begin req_b = 0; drop[1] = 0; end
    else if (fb) begin req_b = 1; dir_b = db; end
    else if (rnd && !req_b && $urandom_range(0, 2) == 0) begin
      req_b = 1; dir_b = 2'($urandom_range(0, 3));
    end
    if (wait_cnt > 0) wait_cnt--;
    else if (!m_done && (req_a || req_b)) begin
      p = (req_a && (!req_b || !m_turn)) ? 0 : 1;
      model_move(p, p ? dir_b : dir_a);
      exp_grant.push_back(p);
      drop[p]  = 1;
      wait_cnt = 2;
    end
  endtask

  task automatic move(input bit fa, input logic [1:0] da, input bit fb, input logic [1:0] db);
    step(0, fa, da, fb, db);
    step(0, 0, 2'b00, 0, 2'b00);
    step(0, 0, 2'b00, 0, 2'b00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    mon_en = 0;
    reset  = 1;
    req_a  = 0;
    req_b  = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    model_init();
    mon_en = 1;
  endtask

  task automatic check_reset_values();
    chk("rst_pos_a", pos_a, 0);
    chk("rst_pos_b", pos_b, 15);
    chk("rst_visited", visited, 16'h8001);
    chk("rst_score_a", score_a, 0);
    chk("rst_score_b", score_b, 0);
    chk("rst_prize", prize, 0);
    chk("rst_turn", turn, 0);
    chk("rst_game_over", game_over, 0);
    chk("rst_pulses", {grant_a, grant_b, prize_valid, blocked}, 0);
  endtask

  // Monitor: pops expectations on output pulses, otherwise checks that state holds.
  initial begin
    res_t r;
    int   g;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (grant_a || grant_b) begin
          if (exp_grant.size() == 0) chk("unexpected_grant", {grant_a, grant_b}, 0);
          else begin
            g = exp_grant.pop_front();
            chk("grant_a", grant_a, g == 0);
            chk("grant_b", grant_b, g == 1);
          end
        end
        if (prize_valid) begin
          if (exp_res.size() == 0) chk("unexpected_prize_valid", prize_valid, 0);
          else begin
            r = exp_res.pop_front();
            chk("prize", prize, r.pz);
            chk("blocked", blocked, r.blk);
            last = r;
          end
        end else begin
          chk("blocked_idle", blocked, 0);
        end
        chk("pos_a", pos_a, last.pa);
        chk("pos_b", pos_b, last.pb);
        chk("score_a", score_a, last.sa);
        chk("score_b", score_b, last.sb);
        chk("visited", visited, last.vis);
        chk("turn", turn, last.trn);
        chk("game_over", game_over, go_exp);
        if (prize_valid && last.done) go_exp = 1;
      end
    end
  end

  initial begin
    int cyc;
    model_init();
    do_reset();
    check_reset_values();

    // Directed opening: first move, tie arbitration, wrap, revisit, saturation, block.
    move(1, 2'b11, 0, 2'b00);
    chk("m1_pos_a", pos_a, 1);
    chk("m1_prize", prize, 1);
    chk("m1_prize_valid", prize_valid, 1);
    chk("m1_score_a", score_a, 1);
    chk("m1_visited", visited, 16'h8003);
    chk("m1_turn", turn, 1);
    move(1, 2'b10, 1, 2'b00);
    chk("tie_pos_b", pos_b, 11);
    chk("tie_prize_b", prize, 5);
    chk("tie_turn", turn, 0);
    move(0, 2'b00, 0, 2'b00);
    chk("held_pos_a", pos_a, 0);
    chk("held_prize_a", prize, 0);
    chk("held_turn", turn, 1);
    move(1, 2'b10, 0, 2'b00);
    chk("wrap_pos_a", pos_a, 3);
    chk("wrap_prize", prize, 3);
    move(1, 2'b11, 0, 2'b00);
    chk("wrap_plus_pos_a", pos_a, 0);
    move(1, 2'b10, 0, 2'b00);
    chk("revisit_prize", prize, 0);
    chk("revisit_score_a", score_a, 4);
    move(1, 2'b01, 0, 2'b00);
    chk("sat_score_a", score_a, 7);
    move(1, 2'b01, 0, 2'b00);
    chk("blk_blocked", blocked, 1);
    chk("blk_prize", prize, 0);
    chk("blk_pos_a", pos_a, 7);
    chk("blk_turn", turn, 1);

    // Random play until the game ends, then requests must be ignored.
    cyc = 0;
    while (!m_done && cyc < 4000) begin step(1, 0, 2'b00, 0, 2'b00); cyc++; end
    repeat (30) step(1, 0, 2'b00, 0, 2'b00);
    chk("game_over_reached", game_over, 1);

    // Reset landing on the MOVE cycle discards the move.
    do_reset();
    step(0, 1, 2'b01, 0, 2'b00);
    do_reset();
    check_reset_values();
    repeat (4) step(0, 0, 2'b00, 0, 2'b00);

    cyc = 0;
    while (!m_done && cyc < 4000) begin step(1, 0, 2'b00, 0, 2'b00); cyc++; end
    repeat (10) step(1, 0, 2'b00, 0, 2'b00);
    chk("game_over_second", game_over, 1);
    chk("grants_drained", exp_grant.size(), 0);
    chk("results_drained", exp_res.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
